// File: rtl/exu_pkg.sv
// exu_pkg: shared ALU op encodings and datapath width for the execute stage
package exu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int SHW_DEF = $clog2(XLEN_DEF);
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
endpackage

// File: rtl/exu_alu_stage_alu_comb.sv
// alu_comb: combinational ALU op decode, barrel shifter drive and result select
module barrel_shifter #(
  parameter int XLEN = exu_pkg::XLEN_DEF,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic            la,
  input  logic            lr,
  input  logic [SHW-1:0]  shift_number,
  output logic [XLEN-1:0] shift_out
);
  logic [XLEN-1:0] st [SHW+1];
  logic fill;
  assign fill = la & data[XLEN-1];
  // left shifts reuse the right-shift network on bit-reversed data
  assign st[0] = lr ? data : {<<{data}};
  for (genvar i = 0; i < SHW; i++) begin : g_stg
    assign st[i+1] = shift_number[i] ? {{(2**i){fill}}, st[i][XLEN-1:2**i]} : st[i];
  end
  assign shift_out = lr ? st[SHW] : {<<{st[SHW]}};
endmodule

module alu_comb
  import exu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  localparam int SHW = $clog2(XLEN);
  logic [XLEN-1:0] shifted;
  logic la, lr;
  assign lr = op == ALU_SRL || op == ALU_SRA;
  assign la = op == ALU_SRA;
  barrel_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .data(a),
    .la(la),
    .lr(lr),
    .shift_number(b[SHW-1:0]),
    .shift_out(shifted)
  );
  always_comb begin
    case (op)
      ALU_ADD:                   result = a + b;
      ALU_SUB:                   result = a - b;
      ALU_AND:                   result = a & b;
      ALU_OR:                    result = a | b;
      ALU_XOR:                   result = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: result = shifted;
      ALU_SLT:                   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:                  result = {{(XLEN-1){1'b0}}, a < b};
      ALU_PASSB:                 result = b;
      default:                   result = '0;
    endcase
  end
endmodule

// File: rtl/exu_alu_stage.sv
// exu_alu_stage: ALU execute stage with 2-entry skid output; EXU_ALU_PERF_CNT_EN adds perf_shift_cnt
module exu_alu_stage
  import exu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
`ifdef EXU_ALU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_shift_cnt
`endif
);
  logic in_xfer, out_xfer, s_valid;
  logic [XLEN-1:0] alu_res, s_result;
  logic [4:0] s_rd;
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  alu_comb #(.XLEN(XLEN)) u_alu (
    .op(in_op),
    .a(in_src1),
    .b(in_src2),
    .result(alu_res)
  );
  // in_ready mirrors !s_valid but is kept as its own flop so it leaves the stage registered
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s_valid <= 1'b0;
      in_ready <= 1'b1;
      out_result <= '0;
      out_rd <= '0;
      s_result <= '0;
      s_rd <= '0;
    end else if (s_valid) begin
      if (out_xfer) begin
        out_result <= s_result;
        out_rd <= s_rd;
        s_valid <= 1'b0;
        s_result <= '0;
        s_rd <= '0;
        in_ready <= 1'b1;
      end
    end else if (in_xfer && out_valid && !out_xfer) begin
      s_result <= alu_res;
      s_rd <= in_rd;
      s_valid <= 1'b1;
      in_ready <= 1'b0;
    end else if (in_xfer) begin
      out_result <= alu_res;
      out_rd <= in_rd;
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end
`ifdef EXU_ALU_PERF_CNT_EN
  always_ff @(posedge clk)
    perf_shift_cnt <= rst ? '0 : perf_shift_cnt + 32'(in_xfer && is_shift(in_op));
`endif
endmodule

// File: tb/tb_exu_alu_stage.sv
// tb_exu_alu_stage: randomized scoreboard bench for exu_alu_stage against an arithmetic reference model
module tb_exu_alu_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [3:0] in_op = 0;
  logic [31:0] in_src1 = 0, in_src2 = 0, out_result;
  logic [4:0] in_rd = 0, out_rd;
`ifdef EXU_ALU_PERF_CNT_EN
  logic [31:0] perf_shift_cnt;
`endif
  logic [36:0] q[$];
  int vecs = 0, errs = 0, outs = 0, stalls = 0, exp_shift = 0;
  bit rnd_bp = 0;

  always #5 clk = ~clk;

  exu_alu_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd)
`ifdef EXU_ALU_PERF_CNT_EN
    , .perf_shift_cnt(perf_shift_cnt)
`endif
  );

  function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
    int sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return $unsigned($signed(a) >>> sh);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string n, logic [36:0] act, logic [36:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      outs++;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_out actual=%0h required=nothing at %0t", {out_rd, out_result}, $time);
      end else chk("result", {out_rd, out_result}, q.pop_front());
    end

  always @(posedge clk)
    if (rnd_bp) begin
      #1;
      out_ready = $urandom_range(0, 3) != 0;
    end

  task automatic issue(int op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    int w = 0;
    in_op = op[3:0];
    in_src1 = a;
    in_src2 = b;
    in_rd = rd;
    in_valid = 1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      w++;
      if (w > 100) begin
        chk("issue_timeout", 0, 1);
        break;
      end
    end
    if (in_ready) begin
      q.push_back({rd, ref_alu(op, a, b)});
      if (op inside {5, 6, 7}) exp_shift++;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  initial begin
    int o0, w;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    issue(7, 32'h80000000, 32'h4, 5'd1);
    chk("latency_valid", out_valid, 1);
    chk("sra", out_result, 32'hF8000000);
    issue(6, 32'h80000000, 32'h4, 5'd2);
    chk("srl", out_result, 32'h08000000);
    issue(5, 32'h1, 32'hFFFFFFFF, 5'd3);
    chk("sll", out_result, 32'h80000000);
    issue(1, 32'h0, 32'h1, 5'd4);
    chk("sub", out_result, 32'hFFFFFFFF);
    issue(8, 32'hFFFFFFFF, 32'h1, 5'd5);
    chk("slt", out_result, 32'h1);
    issue(9, 32'hFFFFFFFF, 32'h1, 5'd6);
    chk("sltu", out_result, 32'h0);
    issue(12, $urandom, $urandom, 5'd0);
    chk("op12_valid", out_valid, 1);
    chk("op12_res", out_result, 32'h0);
    @(posedge clk);
    #1;
    out_ready = 0;
    issue(0, 32'd1, 32'd1, 5'd9);
    issue(0, 32'd2, 32'd2, 5'd10);
    chk("bp_in_ready_low", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold", {out_valid, out_rd, out_result}, {1'b1, 5'd9, 32'd2});
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    stalls = 0;
    o0 = outs;
    for (int i = 0; i < 8; i++) issue($urandom_range(0, 15), pick(), pick(), 5'($urandom));
    @(posedge clk);
    #1;
    chk("stream_stalls", stalls, 0);
    chk("stream_outs", outs - o0, 8);
    out_ready = 0;
    issue(3, 32'hF0, 32'h0F, 5'd7);
    issue(4, 32'hF0, 32'hFF, 5'd8);
    chk("full_in_ready", in_ready, 0);
    rst = 1;
    q.delete();
    exp_shift = 0;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_result", out_result, 0);
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    issue(5, pick(), pick(), 5'd11);
    issue(0, pick(), pick(), 5'd12);
    issue(6, pick(), pick(), 5'd13);
    issue(0, pick(), pick(), 5'd14);
    issue(7, pick(), pick(), 5'd15);
`ifdef EXU_ALU_PERF_CNT_EN
    chk("perf_three_shifts", perf_shift_cnt, 3);
`endif
    rnd_bp = 1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue($urandom_range(0, 15), pick(), pick(), 5'($urandom));
    end
    rnd_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", q.size(), 0);
`ifdef EXU_ALU_PERF_CNT_EN
    chk("perf_total", perf_shift_cnt, exp_shift);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/exu_alu_stage.md
Name: exu_alu_stage

Overview:
- Execute-stage ALU wrapper for the NPC RV32 core.
- Sits between the ID/EX handshake and the writeback path.
- Decodes the ALU op, drives the 32-bit barrel shifter's data/la/lr/shift_number inputs, and selects among shifter, adder, logic and compare results.
- Registers the result behind a valid/ready output with a 2-entry skid buffer, so in_ready is a flop output and timing is cut.

Parameters:
- XLEN, 32, datapath width; must be a power of 2.
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  upstream operand bundle valid.
- in_ready  out  1  stage can accept; registered.
- in_op  in  4  ALU op code from exu_pkg.
- in_src1  in  XLEN  operand A.
- in_src2  in  XLEN  operand B; low SHW bits are the shift amount.
- in_rd  in  5  destination register index, carried through unchanged.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts.
- out_result  out  XLEN  ALU result.
- out_rd  out  5  destination index.

Behaviour:
- Op encodings:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4
  - SLL=5, SRL=6, SRA=7
  - SLT=8, SLTU=9, PASSB=10
  - 11-15 reserved: result 0, still handshaken.
- Shifter drive:
  - SLL: lr=0, la=0.
  - SRL: lr=1, la=0.
  - SRA: lr=1, la=1.
  - shift_number = in_src2[SHW-1:0]; upper src2 bits are ignored.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Storage: main register M (drives out_*) and skid register S.
- State machine on {M.valid, S.valid}:
  - EMPTY (0,0):
    - Input transfer goes to M → HALF.
  - HALF (1,0):
    - Output transfer with no input → EMPTY.
    - Input transfer with output transfer → new bundle into M, stay HALF.
    - Input transfer with no output transfer → new bundle into S → FULL.
  - FULL (1,1):
    - in_ready=0.
    - Output transfer → S moves into M, S is cleared → HALF.
- in_ready = !S.valid, registered.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Throughput: 1 op/cycle while out_ready is held high.
- Outputs do not change while out_valid=1 and out_ready=0; ordering is strictly FIFO.
- Reset:
  - out_valid=0, S.valid=0, in_ready=1.
  - out_result=0, out_rd=0, S data=0.
  - A reset mid-operation discards all in-flight bundles, with no output transfer in that cycle.
- in_valid with in_ready=0: the bundle is ignored. Upstream must hold it.
- out_rd=0 is passed through unchanged. Suppressing writes to x0 is writeback's job.

Optional Feature:
- Macro: EXU_ALU_PERF_CNT_EN.
- Defined:
  - Adds a 32-bit output perf_shift_cnt.
  - Counts input transfers whose op is SLL, SRL or SRA.
  - Wraps at 2^32; reset to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package exu_pkg:
  - XLEN default.
  - 4-bit alu_op_t enum with the encodings above.
  - Helper constant for SHW.
- Sub-module alu_comb, purely combinational:
  - Instantiates the barrel shifter and performs op decode and the result mux.
- exu_alu_stage holds only the skid/handshake state and the optional counter.

Test Plan:
- SRA, src1=0x80000000, src2=0x00000004, out_ready=1 → next cycle out_valid=1, out_result=0xF8000000.
- SRL, same operands → 0x08000000. SLL, src1=1, src2=0xFFFFFFFF (shamt 31) → 0x80000000.
- SUB, 0-1 → 0xFFFFFFFF.
  - SLT, -1 vs 1 → 1.
  - SLTU, 0xFFFFFFFF vs 1 → 0.
  - Op 12 → result 0, out_valid still asserted.
- Back-pressure:
  - out_ready=0, issue ADD 1+1 then ADD 2+2 on consecutive cycles → in_ready drops to 0 the cycle after the second transfer.
  - Raise out_ready → results 2 then 4 in order, rd preserved.
  - in_ready returns to 1.
- Streaming: 8 back-to-back ops with out_ready=1 → 8 results on consecutive cycles, in_ready never deasserts.
- Reset in FULL state → next cycle out_valid=0, in_ready=1, out_result=0; neither buffered bundle is ever emitted.
- With EXU_ALU_PERF_CNT_EN: issue 3 shifts and 2 adds → perf_shift_cnt=3.
